// File: rtl/neopixel_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_rx_pkg
// Description : Shared state encoding and default WS2812 timing constants
//               (in 50 MHz cycles) for the NeoPixel receive monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package neopixel_rx_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

    localparam int c_num_npx      = 17;
    localparam int c_bit_thresh   = 27;
    localparam int c_min_high     = 8;
    localparam int c_max_high     = 60;
    localparam int c_latch_cycles = 1000;
    localparam int c_word_bits    = 24;

    // Nominal transmitter widths, shared with the transmit-side bench.
    localparam int c_t1h    = 36;
    localparam int c_t1l    = 31;
    localparam int c_t0h    = 19;
    localparam int c_t0l    = 41;
    localparam int c_tlatch = 2500;

endpackage
`default_nettype wire

// File: rtl/neopixel_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_rx_sync
// Description : Two-flop synchronizer for the asynchronous data line plus a
//               registered copy, giving level, rise and fall indications.
// Revision    : 1.0 - initial release
// ============================================================================
module neopixel_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_data,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = i_data;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_level = sync2_q;
    assign o_rise  = sync2_q & ~prev_q;
    assign o_fall  = ~sync2_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/neopixel_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_rx_monitor
// Description : WS2812 receiver; classifies bits by high-pulse width, builds
//               24-bit GRB words, reports pixels and frame ends at latch gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module neopixel_rx_monitor
    import neopixel_rx_pkg::*;
#(
    parameter int NUM_NPX      = c_num_npx,
    parameter int BIT_THRESH   = c_bit_thresh,
    parameter int MIN_HIGH     = c_min_high,
    parameter int MAX_HIGH     = c_max_high,
    parameter int LATCH_CYCLES = c_latch_cycles
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         neopixel_data,
    output logic [7:0]                   green,
    output logic [7:0]                   red,
    output logic [7:0]                   blue,
    output logic [$clog2(NUM_NPX)-1:0]   pixel,
    output logic                         pixel_valid,
    output logic                         frame_done,
    output logic [$clog2(NUM_NPX+1)-1:0] pixel_count,
    output logic                         error
);

    localparam int c_cnt_w = $clog2(LATCH_CYCLES + 1);
    localparam int c_pix_w = $clog2(NUM_NPX);
    localparam int c_idx_w = $clog2(NUM_NPX + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_latch  = c_cnt_w'(LATCH_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_thresh = c_cnt_w'(BIT_THRESH);
    localparam logic [c_cnt_w-1:0] c_cnt_minh   = c_cnt_w'(MIN_HIGH);
    localparam logic [c_cnt_w-1:0] c_cnt_maxh   = c_cnt_w'(MAX_HIGH);
    localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_full   = c_idx_w'(NUM_NPX);
    localparam logic [4:0]         c_bit_last   = 5'(c_word_bits - 1);

    logic w_level, w_rise, w_fall;

    neopixel_rx_sync u_sync (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_data  (neopixel_data),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    rx_state_t            state_q, state_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [4:0]           bits_q,  bits_d;
    logic [c_idx_w-1:0]   idx_q,   idx_d;
    logic [22:0]          shift_q, shift_d;

    // Event stage between the FSM and the output registers.
    logic                 ev_pix_q,   ev_pix_d;
    logic                 ev_frame_q, ev_frame_d;
    logic                 ev_err_q,   ev_err_d;
    logic [23:0]          ev_word_q,  ev_word_d;
    logic [c_pix_w-1:0]   ev_idx_q,   ev_idx_d;
    logic [c_idx_w-1:0]   ev_cnt_q,   ev_cnt_d;

    logic [7:0]           green_q, green_d;
    logic [7:0]           red_q,   red_d;
    logic [7:0]           blue_q,  blue_d;
    logic [c_pix_w-1:0]   pixel_q, pixel_d;
    logic                 pixel_valid_q, pixel_valid_d;
    logic                 frame_done_q,  frame_done_d;
    logic [c_idx_w-1:0]   pixel_count_q, pixel_count_d;
    logic                 error_q, error_d;

    logic                 w_bit;
    logic [23:0]          w_word;
    logic                 w_latch;

    always_comb begin
        w_bit   = (count_q >= c_cnt_thresh);
        w_word  = {shift_q, w_bit};

        if (w_rise || w_fall) begin
            count_d = c_cnt_one;
        end else if (count_q != c_cnt_latch) begin
            count_d = count_q + c_cnt_one;
        end else begin
            count_d = count_q;
        end

        // count_d includes the sample currently seen, so this fires on the
        // LATCH_CYCLES-th consecutive low sample.
        w_latch = !w_level && (count_d == c_cnt_latch);
    end

    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        ev_pix_d   = 1'b0;
        ev_frame_d = 1'b0;
        ev_err_d   = 1'b0;
        ev_word_d  = ev_word_q;
        ev_idx_d   = ev_idx_q;
        ev_cnt_d   = ev_cnt_q;

        case (state_q)
            SYNC: begin
                if (w_latch) begin
                    state_d = IDLE;
                    bits_d  = 5'd0;
                    idx_d   = '0;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    if (count_q < c_cnt_minh) begin
                        ev_err_d = 1'b1;
                        state_d  = SYNC;
                    end else begin
                        shift_d = w_word[22:0];
                        state_d = LOW;
                        if (bits_q == c_bit_last) begin
                            bits_d = 5'd0;
                            if (idx_q == c_idx_full) begin
                                ev_err_d = 1'b1;
                                state_d  = SYNC;
                            end else begin
                                ev_pix_d  = 1'b1;
                                ev_word_d = w_word;
                                ev_idx_d  = idx_q[c_pix_w-1:0];
                                idx_d     = idx_q + c_idx_one;
                            end
                        end else begin
                            bits_d = bits_q + 5'd1;
                        end
                    end
                end else if (count_q == c_cnt_maxh) begin
                    ev_err_d = 1'b1;
                    state_d  = SYNC;
                end
            end
            LOW: begin
                if (w_rise) begin
                    state_d = HIGH;
                end else if (w_latch) begin
                    if (bits_q != 5'd0) begin
                        ev_err_d = 1'b1;
                    end else if (idx_q != '0) begin
                        ev_frame_d = 1'b1;
                        ev_cnt_d   = idx_q;
                    end
                    state_d = IDLE;
                    bits_d  = 5'd0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_comb begin
        pixel_valid_d = ev_pix_q;
        frame_done_d  = ev_frame_q;
        error_d       = ev_err_q;
        green_d       = green_q;
        red_d         = red_q;
        blue_d        = blue_q;
        pixel_d       = pixel_q;
        pixel_count_d = pixel_count_q;
        if (ev_pix_q) begin
            green_d = ev_word_q[23:16];
            red_d   = ev_word_q[15:8];
            blue_d  = ev_word_q[7:0];
            pixel_d = ev_idx_q;
        end
        if (ev_frame_q) begin
            pixel_count_d = ev_cnt_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= SYNC;
            count_q       <= '0;
            bits_q        <= 5'd0;
            idx_q         <= '0;
            shift_q       <= '0;
            ev_pix_q      <= 1'b0;
            ev_frame_q    <= 1'b0;
            ev_err_q      <= 1'b0;
            ev_word_q     <= '0;
            ev_idx_q      <= '0;
            ev_cnt_q      <= '0;
            green_q       <= '0;
            red_q         <= '0;
            blue_q        <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            bits_q        <= bits_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            ev_pix_q      <= ev_pix_d;
            ev_frame_q    <= ev_frame_d;
            ev_err_q      <= ev_err_d;
            ev_word_q     <= ev_word_d;
            ev_idx_q      <= ev_idx_d;
            ev_cnt_q      <= ev_cnt_d;
            green_q       <= green_d;
            red_q         <= red_d;
            blue_q        <= blue_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            error_q       <= error_d;
        end
    end

    assign green       = green_q;
    assign red         = red_q;
    assign blue        = blue_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign pixel_count = pixel_count_q;
    assign error       = error_q;

endmodule
`default_nettype wire

// File: doc/neopixel_rx_monitor.md
# neopixel_rx_monitor

Single-wire WS2812/NeoPixel receiver: oversamples the NeoPixel data line at 50 MHz, classifies each bit by its high-pulse width, assembles 24-bit GRB words and reports each pixel with its index. A frame ends at a latch gap. It is the bench/loopback counterpart of the NeoPixel transmit controller, and also serves as the input stage for daisy-chained boards.

## Interface
- NUM_NPX, 17, pixels per frame; pixels beyond this count are errors.
- BIT_THRESH, 27, high width in cycles at or above which a bit decodes as 1.
- MIN_HIGH, 8, shortest legal high pulse in cycles.
- MAX_HIGH, 60, longest legal high pulse in cycles.
- LATCH_CYCLES, 1000, continuous low cycles that end a frame.

- CLOCK_50  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- neopixel_data  in  1  asynchronous NeoPixel line.
- green, red, blue  out  8 each  decoded colour; held between pixels.
- pixel  out  $clog2(NUM_NPX)  index of the reported pixel.
- pixel_valid  out  1  one-cycle strobe; colour and pixel are valid this cycle.
- frame_done  out  1  one-cycle strobe at latch detection.
- pixel_count  out  $clog2(NUM_NPX+1)  pixels in the last completed frame; held.
- error  out  1  one-cycle strobe on any protocol violation.

## Operation
- Input passes through a 2-flop synchronizer. The FSM acts on the synchronized level and its registered copy (edge detect).
- A single cycle counter of width $clog2(LATCH_CYCLES+1) is reloaded to 1 on every edge and saturates.
- States:
  - SYNC: entered from reset and after any error. Waits for LATCH_CYCLES consecutive low cycles, then goes to IDLE with no frame_done.
  - IDLE: rising edge -> HIGH. Bit count and pixel index are 0.
  - HIGH: on falling edge, if count < MIN_HIGH -> error, SYNC. Otherwise shift in (count >= BIT_THRESH) MSB-first and go to LOW. If count reaches MAX_HIGH while still high -> error, SYNC.
  - LOW: rising edge -> HIGH. If count reaches LATCH_CYCLES -> frame end, IDLE.
- Pixel completion: when the 24th bit shifts in, latch {green, red, blue} = shift[23:0] (green first on wire), drive pixel = index, pulse pixel_valid, then increment index and clear bit count.
- Overflow: a completed pixel with index == NUM_NPX gives no pixel_valid. It pulses error and goes to SYNC, and pixel_count is not updated.
- Frame end: if bit count != 0 (partial pixel), pulse error instead of frame_done, go to IDLE, and leave pixel_count unchanged. Otherwise pulse frame_done and load pixel_count = index.
- Frame end with zero pixels (latch gap only) is not a frame: no strobe.

## Timing
- Reset values: all outputs 0, state SYNC, counters 0.
- An edge on neopixel_data sampled at posedge k is seen by the FSM at posedge k+2. Strobes it produces are high during the cycle after posedge k+3.
- The high width is measured as the synchronized high-cycle count, exact ±0 for a clean input.
- Transmitter nominal widths decode as follows:
  - bit 1: ~36 high / ~31 low.
  - bit 0: ~19 high / ~41 low.
  - latch: 2500 low.
- pixel_valid and frame_done are never asserted in the same cycle. error excludes both.
- Reset asserted mid-frame: next cycle returns to reset values. A partial pixel is discarded silently (no error).
- Back-to-back frames need only a latch gap. A rising edge on the cycle the latch is detected is handled by IDLE on the following cycle.

## Structure
- Package neopixel_rx_pkg holds:
  - the state enum rx_state_t {SYNC, IDLE, HIGH, LOW};
  - default timing constants shared with the transmitter bench.
- Sub-module neopixel_rx_sync: 2-flop synchronizer plus registered copy, outputting level, rise and fall.
- The shift register, counter and index register are inline.

## Test plan
- Reset: assert reset for 3 cycles -> all outputs 0. A 1000-cycle low then a rising edge reaches HIGH.
- Single pixel: G=0xA5 R=0x3C B=0xFF at transmitter timing, then 2500 low. Expect one pixel_valid with pixel=0 and those values, then frame_done with pixel_count=1.
- Full loopback: the transmit controller sends 17 distinct pixels, index i = {i, ~i, i^0x55}. Expect 17 ordered pixel_valid matches, then frame_done with pixel_count=17.
- Glitch: a 5-cycle high pulse mid-pixel -> error, no pixel_valid. Recovery on the next frame after a 1000-cycle low.
- Overflow/partial:
  - 18 pixels -> 17 valids, then error, no frame_done.
  - 12 bits then latch -> error, pixel_count unchanged.
- Stuck high: line held high for 61 cycles -> error at count 60, state SYNC.
